// File: rtl/compositor_pkg.sv
// Shared types, frame constants and blend helpers for pixel_compositor.
package compositor_pkg;
  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int FB_ADDR_W = 19;
  localparam int ALPHA_MAX = 8;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    rgb565_t              data;
  } fb_wr_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    rgb565_t    dvi;
    rgb565_t    ccd;
    logic [3:0] a;
    logic       oor;
  } s1_t;

  function automatic logic [3:0] clamp_alpha(input logic [3:0] al);
    return (al > 4'(ALPHA_MAX)) ? 4'(ALPHA_MAX) : al;
  endfunction

  // Weights sum to 8, so the rounded result can never exceed the channel max.
  function automatic logic [4:0] blend5(input logic [4:0] d, input logic [4:0] c,
                                        input logic [3:0] a);
    logic [8:0] acc;
    acc = 9'(d) * 9'(4'(ALPHA_MAX) - a) + 9'(c) * 9'(a) + 9'd4;
    return 5'(acc >> 3);
  endfunction

  function automatic logic [5:0] blend6(input logic [5:0] d, input logic [5:0] c,
                                        input logic [3:0] a);
    logic [9:0] acc;
    acc = 10'(d) * 10'(4'(ALPHA_MAX) - a) + 10'(c) * 10'(a) + 10'd4;
    return 6'(acc >> 3);
  endfunction
endpackage

// File: rtl/pixel_compositor_if.sv
// Pixel input bus plus frame-buffer write port of the compositor.
interface pixel_compositor_if;
  logic                                 val;
  logic [9:0]                           sync_x;
  logic [9:0]                           sync_y;
  logic [4:0]                           dvi_r;
  logic [5:0]                           dvi_g;
  logic [4:0]                           dvi_b;
  logic [4:0]                           ccd_r;
  logic [5:0]                           ccd_g;
  logic [4:0]                           ccd_b;
  logic [3:0]                           alpha;
  logic                                 wr_req;
  logic [compositor_pkg::FB_ADDR_W-1:0] wr_addr;
  logic [15:0]                          wr_data;
  logic                                 wr_ack;

  modport master (
    output val, sync_x, sync_y, dvi_r, dvi_g, dvi_b, ccd_r, ccd_g, ccd_b, alpha, wr_ack,
    input  wr_req, wr_addr, wr_data
  );

  modport slave (
    input  val, sync_x, sync_y, dvi_r, dvi_g, dvi_b, ccd_r, ccd_g, ccd_b, alpha, wr_ack,
    output wr_req, wr_addr, wr_data
  );
endinterface

// File: rtl/pix_fifo.sv
// Synchronous FIFO; a push into a full FIFO succeeds when a pop happens the same cycle.
module pix_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 35
) (
  input  logic         clk_25,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_25) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/pixel_compositor.sv
// Blends DVI/CCD pixels, computes frame-buffer addresses and queues writes.
// Optional PIXEL_COMPOSITOR_CHROMA_KEY_EN: CCD pixels equal to KEY_COLOR are made transparent.
module pixel_compositor
  import compositor_pkg::rgb565_t, compositor_pkg::fb_wr_t, compositor_pkg::s1_t,
         compositor_pkg::FB_ADDR_W, compositor_pkg::clamp_alpha,
         compositor_pkg::blend5, compositor_pkg::blend6;
#(
  parameter int          DEPTH     = 8,
  parameter int          H_RES     = compositor_pkg::H_RES,
  parameter int          V_RES     = compositor_pkg::V_RES,
  parameter logic [15:0] KEY_COLOR = 16'h07E0
) (
  input  logic                clk_25,
  input  logic                rst_n,
  pixel_compositor_if.slave   pif,
  output logic                overflow,
  output logic [15:0]         drop_cnt,
  output logic                frame_done
);
  localparam int STAGES = 1;
  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(H_RES * V_RES - 1);

  s1_t                s1_d, s1_q;
  logic [STAGES:1]    vld_q;
  logic [STAGES:0]    vld_pipe;
  logic [3:0]         a_eff;
  rgb565_t            mix;
  fb_wr_t             push_ent, head;
  logic               push, pop, drop, full, empty;

  assign vld_pipe = {vld_q, pif.val};

  // Stage 1: capture inputs, clamp alpha, flag out-of-range coordinates.
  always_comb begin
    s1_d       = '0;
    s1_d.x     = pif.sync_x;
    s1_d.y     = pif.sync_y;
    s1_d.dvi.r = pif.dvi_r;
    s1_d.dvi.g = pif.dvi_g;
    s1_d.dvi.b = pif.dvi_b;
    s1_d.ccd.r = pif.ccd_r;
    s1_d.ccd.g = pif.ccd_g;
    s1_d.ccd.b = pif.ccd_b;
    s1_d.a     = clamp_alpha(pif.alpha);
    s1_d.oor   = (32'(pif.sync_x) >= H_RES) || (32'(pif.sync_y) >= V_RES);
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      s1_q  <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (pif.val) s1_q <= s1_d;
    end
  end

  // Stage 2: blend and address, feeding the FIFO directly.
  always_comb begin
    a_eff = s1_q.a;
`ifdef PIXEL_COMPOSITOR_CHROMA_KEY_EN
    if (s1_q.ccd == KEY_COLOR) a_eff = '0;
`endif
    mix.r         = blend5(s1_q.dvi.r, s1_q.ccd.r, a_eff);
    mix.g         = blend6(s1_q.dvi.g, s1_q.ccd.g, a_eff);
    mix.b         = blend5(s1_q.dvi.b, s1_q.ccd.b, a_eff);
    // Constant multiply; with H_RES=640 this folds to (y<<9)+(y<<7).
    push_ent.addr = FB_ADDR_W'(s1_q.y) * FB_ADDR_W'(H_RES) + FB_ADDR_W'(s1_q.x);
    push_ent.data = mix;
  end

`ifndef PIXEL_COMPOSITOR_CHROMA_KEY_EN
  // KEY_COLOR only matters when chroma keying is built in.
  logic unused_key;
  assign unused_key = ^KEY_COLOR;
`endif

  assign push = vld_pipe[STAGES] && !s1_q.oor;
  assign pop  = pif.wr_ack && !empty;
  assign drop = push && full && !pop;

  pix_fifo #(.DEPTH(DEPTH), .W($bits(fb_wr_t))) u_fifo (
    .clk_25 (clk_25),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .din    (push_ent),
    .dout   (head),
    .full   (full),
    .empty  (empty)
  );

  // Head is masked while empty so stale storage never shows on the bus.
  assign pif.wr_req  = !empty;
  assign pif.wr_addr = empty ? '0 : head.addr;
  assign pif.wr_data = empty ? '0 : head.data;

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      end
      frame_done <= pop && (head.addr == LAST_ADDR);
    end
  end
endmodule

// File: tb/tb_pixel_compositor.sv
// Randomized scoreboard bench for pixel_compositor with a behavioural reference model.
module tb_pixel_compositor;
  localparam int DEPTH = 8;
  localparam int LAST  = 640 * 480 - 1;

  logic        clk_25 = 1'b0;
  logic        rst_n  = 1'b0;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        frame_done;

  always #20 clk_25 = ~clk_25;

  pixel_compositor_if pif();

  pixel_compositor #(.DEPTH(DEPTH)) dut (
    .clk_25     (clk_25),
    .rst_n      (rst_n),
    .pif        (pif),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .frame_done (frame_done)
  );

  typedef struct { int addr; int data; } exp_t;

  exp_t exp_q[$];
  exp_t pend;
  bit   pend_v, pend_oor;
  int   m_drops;
  bit   m_ovf, fd_next;
  int   fd_seen;
  int   checks, failures;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int ref_pix(input logic [15:0] dvi, input logic [15:0] ccd, input int al);
    int a, r, g, b;
    a = (al > 8) ? 8 : al;
`ifdef PIXEL_COMPOSITOR_CHROMA_KEY_EN
    if (ccd == 16'h07E0) a = 0;
`endif
    r = (int'(dvi[15:11]) * (8 - a) + int'(ccd[15:11]) * a + 4) / 8;
    g = (int'(dvi[10:5])  * (8 - a) + int'(ccd[10:5])  * a + 4) / 8;
    b = (int'(dvi[4:0])   * (8 - a) + int'(ccd[4:0])   * a + 4) / 8;
    return (r << 11) | (g << 5) | b;
  endfunction

  // Monitor + model: runs mid-cycle, when inputs for the next edge are stable.
  always @(negedge clk_25) begin
    exp_t e;
    bit   pop;
    if (!rst_n) begin
      chk("rst_wr_req", pif.wr_req, 0);
      chk("rst_wr_addr", pif.wr_addr, 0);
      chk("rst_wr_data", pif.wr_data, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_frame_done", frame_done, 0);
      exp_q.delete();
      pend_v  = 0;
      m_drops = 0;
      m_ovf   = 0;
      fd_next = 0;
    end else begin
      chk("wr_req", pif.wr_req, exp_q.size() != 0);
      chk("overflow", overflow, m_ovf);
      chk("drop_cnt", drop_cnt, m_drops);
      chk("frame_done", frame_done, fd_next);
      if (frame_done === 1'b1) fd_seen++;
      pop     = pif.wr_ack && exp_q.size() != 0;
      fd_next = 0;
      if (pop) begin
        e = exp_q.pop_front();
        chk("wr_addr", pif.wr_addr, e.addr);
        chk("wr_data", pif.wr_data, e.data);
        fd_next = (e.addr == LAST);
      end
      if (pend_v && !pend_oor) begin
        if (exp_q.size() == DEPTH) begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end else begin
          exp_q.push_back(pend);
        end
      end
      pend_v    = pif.val;
      pend_oor  = (pif.sync_x >= 640) || (pif.sync_y >= 480);
      pend.addr = int'(pif.sync_y) * 640 + int'(pif.sync_x);
      pend.data = ref_pix({pif.dvi_r, pif.dvi_g, pif.dvi_b},
                          {pif.ccd_r, pif.ccd_g, pif.ccd_b}, int'(pif.alpha));
    end
  end

  task automatic drive(input bit v, input int x, input int y, input logic [15:0] dvi,
                       input logic [15:0] ccd, input int al, input bit ack);
    pif.val    = v;
    pif.sync_x = 10'(x);
    pif.sync_y = 10'(y);
    {pif.dvi_r, pif.dvi_g, pif.dvi_b} = dvi;
    {pif.ccd_r, pif.ccd_g, pif.ccd_b} = ccd;
    pif.alpha  = 4'(al);
    pif.wr_ack = ack;
    @(posedge clk_25);
    #1;
  endtask

  task automatic idle(input bit ack);
    drive(0, 0, 0, 16'h0, 16'h0, 0, ack);
  endtask

  task automatic drain();
    idle(1);
    idle(1);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
    chk("drain_wr_req", pif.wr_req, 0);
  endtask

  initial begin
    int fd_base;
    logic [15:0] key_exp;
    checks = 0; failures = 0; fd_seen = 0;
    pif.val = 0; pif.sync_x = 0; pif.sync_y = 0; pif.alpha = 0; pif.wr_ack = 0;
    {pif.dvi_r, pif.dvi_g, pif.dvi_b} = 16'h0;
    {pif.ccd_r, pif.ccd_g, pif.ccd_b} = 16'h0;
    repeat (3) @(posedge clk_25);
    #1 rst_n = 1'b1;

    // Latency and basic blend
    drive(1, 3, 2, 16'hFFFF, 16'h0000, 4, 1);
    chk("lat_n1_wr_req", pif.wr_req, 0);
    idle(1);
    chk("lat_n2_wr_req", pif.wr_req, 1);
    chk("t1_wr_addr", pif.wr_addr, 1283);
    chk("t1_wr_data", pif.wr_data, 16'h8410);
    drain();

    // Alpha 8, saturated 12, and 0
    drive(1, 10, 5, 16'h1234, 16'hBEEF, 8, 1);
    drive(1, 11, 5, 16'h1234, 16'hBEEF, 12, 1);
    drive(1, 12, 5, 16'h1234, 16'hBEEF, 0, 1);
    drain();

    // Full FIFO with ack held: pops make room, no drops
    for (int i = 0; i < DEPTH; i++) drive(1, i, 7, 16'($urandom), 16'($urandom), int'($urandom_range(0, 15)), 0);
    for (int i = 0; i < 20; i++) drive(1, i, 8, 16'($urandom), 16'($urandom), int'($urandom_range(0, 15)), 1);
    drain();
    chk("full_ack_drop_cnt", drop_cnt, 0);
    chk("full_ack_overflow", overflow, 0);

    // Overflow: 10 pixels, no ack
    for (int i = 0; i < 10; i++) drive(1, 100 + i, 9, 16'($urandom), 16'($urandom), int'($urandom_range(0, 15)), 0);
    idle(0);
    idle(0);
    chk("ovf_overflow", overflow, 1);
    chk("ovf_drop_cnt", drop_cnt, 2);
    chk("ovf_wr_req", pif.wr_req, 1);
    drain();

    // Out-of-range discard and last-pixel frame_done
    fd_base = fd_seen;
    drive(1, 640, 0, 16'h1111, 16'h2222, 3, 1);
    drive(1, 0, 480, 16'h1111, 16'h2222, 3, 1);
    drive(1, 639, 479, 16'h3333, 16'h4444, 5, 1);
    drain();
    idle(1);
    chk("frame_done_count", fd_seen - fd_base, 1);
    chk("oor_drop_cnt", drop_cnt, 2);

    // Chroma key colour as CCD with alpha 8
`ifdef PIXEL_COMPOSITOR_CHROMA_KEY_EN
    key_exp = 16'hA5A5;
`else
    key_exp = 16'h07E0;
`endif
    drive(1, 1, 1, 16'hA5A5, 16'h07E0, 8, 0);
    idle(0);
    chk("key_wr_data", pif.wr_data, key_exp);
    drain();

    // Reset mid-operation discards queued pixels and clears status
    for (int i = 0; i < 5; i++) drive(1, i, 20, 16'($urandom), 16'($urandom), 4, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_req", pif.wr_req, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_drop_cnt", drop_cnt, 0);
    idle(0);
    idle(0);
    rst_n = 1'b1;
    idle(1);

    // Random traffic with periodic ack stalls
    for (int i = 0; i < 3000; i++) begin
      int x, y;
      bit ack;
      x   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(640, 1023)) : int'($urandom_range(0, 639));
      y   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(480, 1023)) : int'($urandom_range(0, 479));
      if ($urandom_range(0, 63) == 0) begin x = 639; y = 479; end
      ack = ((i / 40) % 4 == 3) ? 1'b0 : ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, x, y, 16'($urandom),
            ($urandom_range(0, 7) == 0) ? 16'h07E0 : 16'($urandom),
            int'($urandom_range(0, 15)), ack);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
